// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state, size encodings and address translation for the data-side bridge
package dmem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} stateT;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  function automatic logic [31:0] ksegXlate(input logic [31:0] addr, input bit enable);
    return (enable && addr[31:30] == 2'b10) ? {3'b000, addr[28:0]} : addr;
  endfunction
endpackage

// File: rtl/dmem_bridge.sv
// dmem_bridge: runs the M-stage access as one SRAM-like bus transaction, stalling until it completes
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en_i,
  input  logic [3:0]  mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        stall_o,
  output logic        exc_o,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  output logic [3:0]  data_wstrb_o,
  input  logic        data_addr_ok_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_data_ok_i
);
  stateT state;
  logic orphan, wrPending, mis, issue, lost;
  assign mis = (mem_size_i == SZ_HALF && mem_addr_i[0]) ||
               (mem_size_i == SZ_WORD && mem_addr_i[1:0] != 2'b00);
  assign issue = mem_en_i && !mis && state == IDLE;
  // A flush in the completing cycle abandons the transaction just like an earlier one
  assign lost = orphan || !mem_en_i;
  assign exc_o = rst && mem_en_i && mis;
  assign data_req_o = rst && issue;
  assign stall_o = rst && mem_en_i && !mis && state != DONE;
  assign data_wr_o = rst && (|mem_we_i);
  assign data_size_o = rst ? mem_size_i : 2'b00;
  assign data_addr_o = rst ? ksegXlate(mem_addr_i, KSEG_MAP) : 32'h0;
  assign data_wdata_o = rst ? mem_wdata_i : 32'h0;
  assign data_wstrb_o = rst ? mem_we_i : 4'h0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      orphan <= 1'b0;
      wrPending <= 1'b0;
      mem_rdata_o <= 32'h0;
    end else begin
      case (state)
        IDLE: if (issue && data_addr_ok_i) begin
          state <= data_data_ok_i ? DONE : WAIT;
          wrPending <= |mem_we_i;
          if (data_data_ok_i && !(|mem_we_i)) mem_rdata_o <= data_rdata_i;
        end
        WAIT: if (data_data_ok_i) begin
          state <= lost ? IDLE : DONE;
          orphan <= 1'b0;
          if (!lost && !wrPending) mem_rdata_o <= data_rdata_i;
        end else if (!mem_en_i) orphan <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed stimulus checked every cycle against a transaction-level model
module tb_dmem_bridge;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_en_i = 1'b0;
  logic [3:0] mem_we_i = '0;
  logic [1:0] mem_size_i = '0;
  logic [31:0] mem_addr_i = '0, mem_wdata_i = '0, data_rdata_i = '0;
  logic data_addr_ok_i = 1'b0, data_data_ok_i = 1'b0;
  logic [31:0] mem_rdata_o, data_addr_o, data_wdata_o;
  logic stall_o, exc_o, data_req_o, data_wr_o;
  logic [1:0] data_size_o;
  logic [3:0] data_wstrb_o;
  int errors = 0, checks = 0;

  dmem_bridge #(.KSEG_MAP(1'b1)) dut (
    .clk(clk), .rst(rst), .mem_en_i(mem_en_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
    .stall_o(stall_o), .exc_o(exc_o), .data_req_o(data_req_o), .data_wr_o(data_wr_o),
    .data_size_o(data_size_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_wstrb_o(data_wstrb_o), .data_addr_ok_i(data_addr_ok_i), .data_rdata_i(data_rdata_i),
    .data_data_ok_i(data_data_ok_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  // Model: a transaction is either owed by the bus, or the M instruction is retiring
  bit busOwed = 0, flushed = 0, retiring = 0, owedRead = 0;
  logic [31:0] mRdata = '0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busOwed <= 0; flushed <= 0; retiring <= 0; owedRead <= 0; mRdata <= '0;
    end else if (retiring) retiring <= 0;
    else if (busOwed) begin
      if (data_data_ok_i) begin
        busOwed <= 0;
        flushed <= 0;
        if (!flushed && mem_en_i) begin
          retiring <= 1;
          if (owedRead) mRdata <= data_rdata_i;
        end
      end else if (!mem_en_i) flushed <= 1;
    end else if (mem_en_i && !misaligned(mem_size_i, mem_addr_i) && data_addr_ok_i) begin
      if (data_data_ok_i) begin
        retiring <= 1;
        if (mem_we_i == 4'h0) mRdata <= data_rdata_i;
      end else begin
        busOwed <= 1;
        owedRead <= mem_we_i == 4'h0;
      end
    end
  end

  always @(negedge clk) begin
    bit live, on;
    logic [31:0] eAddr;
    #2;
    on = rst;
    live = mem_en_i && !misaligned(mem_size_i, mem_addr_i);
    eAddr = (mem_addr_i >= 32'h8000_0000 && mem_addr_i < 32'hC000_0000) ? mem_addr_i % 32'h2000_0000 : mem_addr_i;
    chk("m_req", data_req_o, on && live && !busOwed && !retiring);
    chk("m_stall", stall_o, on && live && !retiring);
    chk("m_exc", exc_o, on && mem_en_i && misaligned(mem_size_i, mem_addr_i));
    chk("m_wr", data_wr_o, on && mem_we_i != 0);
    chk("m_size", data_size_o, on ? mem_size_i : 2'd0);
    chk("m_addr", data_addr_o, on ? eAddr : 32'h0);
    chk("m_wdata", data_wdata_o, on ? mem_wdata_i : 32'h0);
    chk("m_wstrb", data_wstrb_o, on ? mem_we_i : 4'h0);
    chk("m_rdata", mem_rdata_o, mRdata);
  end

  task automatic drive(input logic en, input logic [3:0] we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic aok, input logic dok, input logic [31:0] rd);
    @(negedge clk);
    mem_en_i = en; mem_we_i = we; mem_size_i = sz; mem_addr_i = a; mem_wdata_i = wd;
    data_addr_ok_i = aok; data_data_ok_i = dok; data_rdata_i = rd;
    #3;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 2, 32'h40, 0, 1, 1, 32'h5555_5555);
    chk("rst_req", data_req_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_rdata", mem_rdata_o, 0);
    @(negedge clk); rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // word load through kseg translation
    drive(1, 0, 2, 32'h8000_0010, 0, 1, 0, 0);
    chk("ld_addr", data_addr_o, 32'h10);
    chk("ld_wr", data_wr_o, 0);
    chk("ld_stall0", stall_o, 1);
    drive(1, 0, 2, 32'h8000_0010, 0, 0, 1, 32'hDEAD_BEEF);
    chk("ld_stall1", stall_o, 1);
    chk("ld_req1", data_req_o, 0);
    drive(1, 0, 2, 32'h8000_0010, 0, 0, 0, 0);
    chk("ld_done_stall", stall_o, 0);
    chk("ld_rdata", mem_rdata_o, 32'hDEAD_BEEF);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // byte store with addr_ok backpressure
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'b1000, 0, 32'h103, 32'hAB00_0000, 0, 0, 0);
      chk("st_req_wait", data_req_o, 1);
      chk("st_addr_wait", data_addr_o, 32'h103);
      chk("st_wstrb_wait", data_wstrb_o, 4'b1000);
    end
    drive(1, 4'b1000, 0, 32'h103, 32'hAB00_0000, 1, 0, 0);
    chk("st_req_acc", data_req_o, 1);
    chk("st_wr", data_wr_o, 1);
    drive(1, 4'b1000, 0, 32'h103, 32'hAB00_0000, 0, 1, 32'h1234_5678);
    chk("st_stall_wait", stall_o, 1);
    drive(1, 4'b1000, 0, 32'h103, 32'hAB00_0000, 0, 0, 0);
    chk("st_done_stall", stall_o, 0);
    chk("st_rdata_kept", mem_rdata_o, 32'hDEAD_BEEF);
    // misaligned accesses
    drive(1, 0, 1, 32'h1, 0, 0, 0, 0);
    chk("mis_h_exc", exc_o, 1);
    chk("mis_h_req", data_req_o, 0);
    chk("mis_h_stall", stall_o, 0);
    drive(1, 4'hF, 2, 32'h2, 32'h1, 0, 0, 0);
    chk("mis_w_exc", exc_o, 1);
    chk("mis_w_req", data_req_o, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // flush mid-transaction, new load during the orphan drain
    drive(1, 0, 2, 32'h200, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 2, 32'h300, 0, 0, 0, 0);
    chk("fl_stall", stall_o, 1);
    chk("fl_req", data_req_o, 0);
    drive(1, 0, 2, 32'h300, 0, 0, 1, 32'h1111_1111);
    chk("fl_req_drain", data_req_o, 0);
    drive(1, 0, 2, 32'h300, 0, 1, 0, 0);
    chk("fl_reissue", data_req_o, 1);
    chk("fl_rdata_kept", mem_rdata_o, 32'hDEAD_BEEF);
    chk("fl_stall_idle", stall_o, 1);
    drive(1, 0, 2, 32'h300, 0, 0, 1, 32'h2222_2222);
    drive(1, 0, 2, 32'h300, 0, 0, 0, 0);
    chk("fl_done_stall", stall_o, 0);
    chk("fl_rdata", mem_rdata_o, 32'h2222_2222);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // zero-wait bus
    drive(1, 0, 2, 32'h40, 0, 1, 1, 32'h3333_3333);
    chk("zw_stall", stall_o, 1);
    chk("zw_req", data_req_o, 1);
    drive(1, 0, 2, 32'h40, 0, 0, 0, 0);
    chk("zw_done_stall", stall_o, 0);
    chk("zw_no_req", data_req_o, 0);
    chk("zw_rdata", mem_rdata_o, 32'h3333_3333);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // reset while waiting for data_ok
    drive(1, 0, 2, 32'h50, 0, 1, 0, 0);
    drive(1, 0, 2, 32'h50, 0, 0, 0, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    #2;
    chk("mr_stall", stall_o, 0);
    chk("mr_req", data_req_o, 0);
    chk("mr_addr", data_addr_o, 0);
    chk("mr_rdata", mem_rdata_o, 0);
    @(negedge clk); rst = 1'b1;
    drive(1, 0, 2, 32'h60, 0, 1, 0, 0);
    chk("mr_req_after", data_req_o, 1);
    drive(1, 0, 2, 32'h60, 0, 0, 1, 32'h4444_4444);
    drive(1, 0, 2, 32'h60, 0, 0, 0, 0);
    chk("mr_done_stall", stall_o, 0);
    chk("mr_rdata_after", mem_rdata_o, 32'h4444_4444);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
